// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl - sequencing controller for the FSM-controlled calculator.
//
// Collects NUM_OPS operands from the switches, one per enter press, then
// latches the operation select and holds the result display. A press in
// RESULT chains the result back in as operand 0 and collects the rest.
//
// Optional feature macro: CALC_TIMEOUT_EN. When defined, an inactivity
// timer aborts to IDLE after TIMEOUT_CYC quiet cycles in GET/DISP/COMPUTE.
// When undefined, there is no timer and timeout is tied low.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   start           level, begins a calculation (IDLE and RESULT only)
//   enter           level, synchronised and debounced push button
//   abort           level, return to IDLE
//   sw_data         operand value from the switches
//   op_sel          operation select
//   op_code         datapath command
//   wr_en           one-cycle operand write strobe
//   wr_addr         operand register index
//   wr_data         operand write data (= sw_data)
//   compute_op      operation: live in COMPUTE, latched otherwise
//   state           current state for the HEX display
//   done            high in RESULT
//   timeout         one-cycle pulse on inactivity abort
//
// state   | meaning
// --------+------------------------------------------------
// IDLE    | waiting for start
// CLEAR   | clear datapath, reset operand index
// GET     | wait for enter press, write operand on the rise
// DISP    | show operand, wait for enter release
// CHAIN   | copy result into operand 0, continue at index 1
// COMPUTE | op_sel shown live, press to latch it
// RESULT  | hold result display

module calc_seq_ctrl #(
  parameter int DATA_W      = 4,
  parameter int NUM_OPS     = 2,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        enter,
  input  logic                        abort,
  input  logic [DATA_W-1:0]           sw_data,
  input  logic [1:0]                  op_sel,
  output logic [2:0]                  op_code,
  output logic                        wr_en,
  output logic [$clog2(NUM_OPS)-1:0]  wr_addr,
  output logic [DATA_W-1:0]           wr_data,
  output logic [1:0]                  compute_op,
  output logic [2:0]                  state,
  output logic                        done,
  output logic                        timeout
);

  localparam int IDX_W = $clog2(NUM_OPS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_CLEAR   = 3'b001,
    S_GET     = 3'b010,
    S_DISP    = 3'b011,
    S_CHAIN   = 3'b100,
    S_COMPUTE = 3'b110,
    S_RESULT  = 3'b111
  } state_t;

  localparam logic [2:0] OP_NOOP     = 3'b000;
  localparam logic [2:0] OP_LOAD_RES = 3'b001;
  localparam logic [2:0] OP_DISP_OPD = 3'b010;
  localparam logic [2:0] OP_COMPUTE  = 3'b101;
  localparam logic [2:0] OP_DISP_RES = 3'b110;
  localparam logic [2:0] OP_CLEAR    = 3'b111;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              enter_q, enter_d;
  logic [1:0]        compute_op_q, compute_op_d;
  logic              enter_rise;
  logic              timeout_hit;

  assign enter_rise = enter & ~enter_q;
  assign enter_d    = enter;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      enter_q      <= 1'b0;
      compute_op_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      enter_q      <= enter_d;
      compute_op_q <= compute_op_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    compute_op_d = compute_op_q;
    if (abort || timeout_hit) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_d = S_CLEAR;
        end
        S_CLEAR: begin
          idx_d   = '0;
          state_d = S_GET;
        end
        S_GET: begin
          if (enter_rise) state_d = S_DISP;
        end
        S_DISP: begin
          // Waiting for release here is what makes one press one operand.
          if (!enter) begin
            if (idx_q == IDX_W'(NUM_OPS - 1)) begin
              state_d = S_COMPUTE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = S_GET;
            end
          end
        end
        S_COMPUTE: begin
          if (enter_rise) begin
            compute_op_d = op_sel;
            state_d      = S_RESULT;
          end
        end
        S_RESULT: begin
          if (start)           state_d = S_CLEAR;
          else if (enter_rise) state_d = S_CHAIN;
        end
        S_CHAIN: begin
          // Operand 0 now holds the previous result.
          idx_d   = IDX_W'(1);
          state_d = S_GET;
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    op_code = OP_NOOP;
    case (state_q)
      S_CLEAR:   op_code = OP_CLEAR;
      S_DISP:    op_code = OP_DISP_OPD;
      S_CHAIN:   op_code = OP_LOAD_RES;
      S_COMPUTE: op_code = OP_COMPUTE;
      S_RESULT:  op_code = OP_DISP_RES;
      default:   op_code = OP_NOOP;
    endcase
  end

  // No write when the same edge is leaving for IDLE.
  assign wr_en      = (state_q == S_GET) && enter_rise && !abort && !timeout_hit;
  assign wr_addr    = idx_q;
  assign wr_data    = sw_data;
  assign compute_op = (state_q == S_COMPUTE) ? op_sel : compute_op_q;
  assign state      = state_q;
  assign done       = (state_q == S_RESULT);

`ifdef CALC_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tmr_active;

  assign tmr_active  = (state_q == S_GET) || (state_q == S_DISP) ||
                       (state_q == S_COMPUTE);
  assign timeout_hit = tmr_active && (tmr_q == TMR_W'(TIMEOUT_CYC));
  // abort outranks the timeout, so the pulse is suppressed when both fire.
  assign timeout     = timeout_hit && !abort;

  always_comb begin
    tmr_d = tmr_q + TMR_W'(1);
    if (!tmr_active || (state_d != state_q) || (enter != enter_q)) begin
      tmr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmr_q <= '0;
    else       tmr_q <= tmr_d;
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl: a two-operand instance (short timeout)
// and a four-operand instance (long timeout) sharing clock and reset.
module tb_calc_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw_data;
  logic [1:0] op_sel;

  logic       start, enter, abort;
  logic [2:0] op_code, state, state_unused;
  logic       wr_en, done, timeout;
  logic [0:0] wr_addr;
  logic [3:0] wr_data;
  logic [1:0] compute_op;

  logic       start4, enter4, abort4;
  logic [2:0] op_code4, state4;
  logic       wr_en4, done4, timeout4;
  logic [1:0] wr_addr4;
  logic [3:0] wr_data4;
  logic [1:0] compute_op4;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  calc_seq_ctrl #(.DATA_W(4), .NUM_OPS(2), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .reset(reset), .start(start), .enter(enter), .abort(abort),
    .sw_data(sw_data), .op_sel(op_sel), .op_code(op_code), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .compute_op(compute_op),
    .state(state), .done(done), .timeout(timeout)
  );

  calc_seq_ctrl #(.DATA_W(4), .NUM_OPS(4), .TIMEOUT_CYC(1000)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .enter(enter4), .abort(abort4),
    .sw_data(sw_data), .op_sel(op_sel), .op_code(op_code4), .wr_en(wr_en4),
    .wr_addr(wr_addr4), .wr_data(wr_data4), .compute_op(compute_op4),
    .state(state4), .done(done4), .timeout(timeout4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Press on the 2-operand instance; returns one cycle after release.
  task automatic press(input logic [3:0] val, input logic [31:0] exp_addr);
    sw_data = val;
    enter   = 1'b1;
    #1;
    chk("wr_en", wr_en, 1);
    chk("wr_addr", wr_addr, exp_addr);
    chk("wr_data", wr_data, val);
    step();
    chk("disp_state", state, 3);
    chk("disp_opcode", op_code, 3'b010);
    chk("wr_en_once", wr_en, 0);
    enter = 1'b0;
    step();
  endtask

  task automatic press4(input logic [3:0] val, input logic [31:0] exp_addr);
    sw_data = val;
    enter4  = 1'b1;
    #1;
    chk("wr_en4", wr_en4, 1);
    chk("wr_addr4", wr_addr4, exp_addr);
    chk("wr_data4", wr_data4, val);
    step();
    chk("disp_state4", state4, 3);
    enter4 = 1'b0;
    step();
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    start = 0; enter = 0; abort = 0;
    start4 = 0; enter4 = 0; abort4 = 0;
    sw_data = 0; op_sel = 0;
    #12;
    chk("rst_state", state, 0);
    chk("rst_opcode", op_code, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_compute_op", compute_op, 0);
    reset = 1'b0;
    step();

    // Two-operand calculation: 3, 5, op 01.
    start = 1'b1;
    step();
    chk("clear_state", state, 1);
    chk("clear_opcode", op_code, 3'b111);
    start = 1'b0;
    step();
    chk("get_state", state, 2);
    press(4'd3, 0);
    chk("get1_state", state, 2);
    chk("get1_addr", wr_addr, 1);
    press(4'd5, 1);
    chk("compute_state", state, 6);
    chk("compute_opcode", op_code, 3'b101);
    op_sel = 2'b01;
    #1;
    chk("compute_live", compute_op, 2'b01);
    enter = 1'b1;
    step();
    chk("result_state", state, 7);
    chk("result_done", done, 1);
    chk("result_opcode", op_code, 3'b110);
    op_sel = 2'b10;
    #1;
    chk("result_latched", compute_op, 2'b01);
    enter = 1'b0;
    step();
    chk("result_hold", state, 7);

    // Chain: result becomes operand 0, next write goes to index 1.
    enter = 1'b1;
    step();
    chk("chain_state", state, 4);
    chk("chain_opcode", op_code, 3'b001);
    step();
    chk("chain_get", state, 2);
    chk("chain_addr", wr_addr, 1);
    chk("chain_no_wr", wr_en, 0);
    enter = 1'b0;
    step();
    press(4'd7, 1);
    chk("chain_compute", state, 6);

    // Abort from COMPUTE, then abort in DISP with idx 1.
    abort = 1'b1;
    step();
    chk("abort_compute", state, 0);
    start = 1'b1;
    step();
    chk("abort_start_idle", state, 0);
    abort = 1'b0;
    step();
    chk("start_after_abort", state, 1);
    start = 1'b0;
    step();
    press(4'd2, 0);
    sw_data = 4'd4;
    enter = 1'b1;
    step();
    chk("disp_idx1_state", state, 3);
    chk("disp_idx1_addr", wr_addr, 1);
    abort = 1'b1;
    step();
    chk("abort_disp_state", state, 0);
    chk("abort_disp_idx", wr_addr, 0);
    abort = 1'b0;
    enter = 1'b0;
    step();

    // Async reset in GET at index 1, between clock edges.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    press(4'd1, 0);
    chk("pre_reset_addr", wr_addr, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_addr", wr_addr, 0);
    chk("async_rst_op", compute_op, 0);
    chk("async_rst_opcode", op_code, 0);
    reset = 1'b0;
    step();

    // Four-operand instance with a held first press.
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    chk("get4_state", state4, 2);
    sw_data = 4'd1;
    enter4 = 1'b1;
    #1;
    chk("held_addr", wr_addr4, 0);
    cnt = wr_en4 ? 1 : 0;
    for (int i = 1; i < 20; i++) begin
      step();
      if (wr_en4) cnt++;
    end
    chk("held_pulses", cnt, 1);
    chk("held_state", state4, 3);
    enter4 = 1'b0;
    step();
    chk("after_held", state4, 2);
    press4(4'd2, 1);
    press4(4'd3, 2);
    chk("third_release", state4, 2);
    press4(4'd4, 3);
    chk("fourth_release", state4, 6);
    op_sel = 2'b11;
    enter4 = 1'b1;
    step();
    chk("result4", state4, 7);
    chk("result4_op", compute_op4, 2'b11);
    enter4 = 1'b0;
    step();
    start4 = 1'b1;
    enter4 = 1'b1;
    step();
    chk("start_beats_enter", state4, 1);
    start4 = 1'b0;
    enter4 = 1'b0;
    step();

    // Inactivity in GET on the short-timeout instance.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("to_get", state, 2);
    chk("to_quiet", timeout, 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (timeout) cnt++;
    end
`ifdef CALC_TIMEOUT_EN
    chk("timeout_pulses", cnt, 1);
    chk("timeout_state", state, 0);
`else
    chk("timeout_pulses", cnt, 0);
    chk("timeout_state", state, 2);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
